// File: rtl/usb_command_decoder.sv
// Command decoder for the USB slave-FIFO control path.
// It turns strobed 16-bit control words into acquisition, soft-reset and configuration-write actions.
module usb_command_decoder #(
  parameter int TIMEOUT = 1024,
  parameter int NREG    = 8
) (
  input  logic        IFCLK,
  input  logic        nRESET,
  input  logic        Ctr_rd_en,
  input  logic [15:0] ControlWord,
  output logic        Acq_Start_Stop,
  output logic        cfg_wr_en,
  output logic [7:0]  cfg_addr,
  output logic [15:0] cfg_data,
  output logic        sw_reset,
  output logic        cmd_busy,
  output logic [7:0]  err_count
);

  localparam logic [15:0] CMD_START = 16'hF0F0;
  localparam logic [15:0] CMD_STOP  = 16'hF0F1;
  localparam logic [15:0] CMD_SWRST = 16'hF0FA;
  localparam logic [7:0]  CMD_WRHDR = 8'hA0;
  localparam int          TW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {
    IDLE,
    WAIT_DATA
  } state_e;

  state_e          state_q, state_d;
  logic            acq_q, acq_d;
  logic            cfg_wr_en_q, cfg_wr_en_d;
  logic [7:0]      cfg_addr_q, cfg_addr_d;
  logic [15:0]     cfg_data_q, cfg_data_d;
  logic            sw_reset_q, sw_reset_d;
  logic [7:0]      err_q, err_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            err_inc;
  logic            hdr_valid;

  assign hdr_valid = (ControlWord[15:8] == CMD_WRHDR) && (32'(ControlWord[7:0]) < NREG);

  // NOTE: every always_comb output gets a default first, so no path can leave a latch.
  always_comb begin
    state_d     = state_q;
    acq_d       = acq_q;
    cfg_wr_en_d = 1'b0;
    cfg_addr_d  = cfg_addr_q;
    cfg_data_d  = cfg_data_q;
    sw_reset_d  = 1'b0;
    tmo_d       = tmo_q;
    err_inc     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (Ctr_rd_en) begin
          if (ControlWord == CMD_START) begin
            acq_d = 1'b1;
          end else if (ControlWord == CMD_STOP) begin
            acq_d = 1'b0;
          end else if (ControlWord == CMD_SWRST) begin
            acq_d      = 1'b0;
            sw_reset_d = 1'b1;
          end else if (hdr_valid) begin
            cfg_addr_d = ControlWord[7:0];
            tmo_d      = TW'(TIMEOUT);
            state_d    = WAIT_DATA;
          end else begin
            err_inc = 1'b1;
          end
        end
      end
      WAIT_DATA: begin
        // A strobe wins over expiry, even in the cycle the counter sits at zero.
        if (Ctr_rd_en) begin
          cfg_data_d  = ControlWord;
          cfg_wr_en_d = 1'b1;
          state_d     = IDLE;
        end else if (tmo_q == '0) begin
          err_inc = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    err_d = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge IFCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q     <= IDLE;
      acq_q       <= 1'b0;
      cfg_wr_en_q <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_data_q  <= '0;
      sw_reset_q  <= 1'b0;
      err_q       <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      acq_q       <= acq_d;
      cfg_wr_en_q <= cfg_wr_en_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_data_q  <= cfg_data_d;
      sw_reset_q  <= sw_reset_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
    end
  end

  assign Acq_Start_Stop = acq_q;
  assign cfg_wr_en      = cfg_wr_en_q;
  assign cfg_addr       = cfg_addr_q;
  assign cfg_data       = cfg_data_q;
  assign sw_reset       = sw_reset_q;
  assign cmd_busy       = (state_q == WAIT_DATA);
  assign err_count      = err_q;

endmodule

// File: tb/tb_usb_command_decoder.sv
// Self-checking bench for usb_command_decoder: directed scenarios plus random traffic,
// compared every cycle against a transaction-level reference model.
module tb_usb_command_decoder;

  localparam int T    = 40;
  localparam int NREG = 8;

  logic        IFCLK = 1'b0;
  logic        nRESET = 1'b0;
  logic        Ctr_rd_en = 1'b0;
  logic [15:0] ControlWord = '0;
  logic        Acq_Start_Stop, cfg_wr_en, sw_reset, cmd_busy;
  logic [7:0]  cfg_addr, err_count;
  logic [15:0] cfg_data;

  int checks = 0;
  int errors = 0;

  // Reference model: outcome of each strobed word, with a cycle deadline for pending writes.
  bit          m_acq, m_wr, m_swr, m_pending;
  logic [7:0]  m_addr, m_err;
  logic [15:0] m_data;
  int          cyc, m_deadline;

  usb_command_decoder #(.TIMEOUT(T), .NREG(NREG)) dut (
    .IFCLK(IFCLK), .nRESET(nRESET), .Ctr_rd_en(Ctr_rd_en), .ControlWord(ControlWord),
    .Acq_Start_Stop(Acq_Start_Stop), .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .sw_reset(sw_reset), .cmd_busy(cmd_busy), .err_count(err_count)
  );

  always #5 IFCLK = ~IFCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acq = 0; m_wr = 0; m_swr = 0; m_pending = 0;
    m_addr = '0; m_err = '0; m_data = '0; m_deadline = 0;
  endtask

  task automatic model_err();
    if (m_err != 8'hFF) m_err = m_err + 8'd1;
  endtask

  task automatic model_step(input bit en, input logic [15:0] w);
    m_wr  = 0;
    m_swr = 0;
    if (m_pending) begin
      if (en) begin
        m_wr = 1; m_data = w; m_pending = 0;
      end else if (cyc == m_deadline) begin
        m_pending = 0; model_err();
      end
    end else if (en) begin
      if (w == 16'hF0F0) m_acq = 1;
      else if (w == 16'hF0F1) m_acq = 0;
      else if (w == 16'hF0FA) begin m_swr = 1; m_acq = 0; end
      else if (w[15:8] == 8'hA0 && int'(w[7:0]) < NREG) begin
        m_pending  = 1;
        m_addr     = w[7:0];
        m_deadline = cyc + T + 1;
      end else model_err();
    end
    cyc++;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".acq"},  32'(Acq_Start_Stop), 32'(m_acq));
    check({tag, ".wr"},   32'(cfg_wr_en),      32'(m_wr));
    check({tag, ".addr"}, 32'(cfg_addr),       32'(m_addr));
    check({tag, ".data"}, 32'(cfg_data),       32'(m_data));
    check({tag, ".swr"},  32'(sw_reset),       32'(m_swr));
    check({tag, ".busy"}, 32'(cmd_busy),       32'(m_pending));
    check({tag, ".err"},  32'(err_count),      32'(m_err));
  endtask

  task automatic step(input string tag, input bit en, input logic [15:0] w);
    @(negedge IFCLK);
    Ctr_rd_en   = en;
    ControlWord = w;
    @(posedge IFCLK);
    model_step(en, w);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 16'h0000);
  endtask

  // Assert reset between edges and check outputs before any further clock edge.
  task automatic async_reset(input string tag);
    #2;
    nRESET = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    @(negedge IFCLK);
    Ctr_rd_en = 1'b0;
    nRESET    = 1'b1;
  endtask

  function automatic logic [15:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 16'hF0F0;
      1:       return 16'hF0F1;
      2:       return 16'hF0FA;
      3, 4:    return {8'hA0, 8'($urandom_range(0, NREG + 3))};
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    cyc = 0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge IFCLK);
    nRESET = 1'b1;

    // Start, then stop 20 cycles later; repeated start/stop are no-ops.
    step("start", 1'b1, 16'hF0F0);
    idle("run", 19);
    step("stop", 1'b1, 16'hF0F1);
    step("stop_again", 1'b1, 16'hF0F1);
    step("start2", 1'b1, 16'hF0F0);
    step("start_again", 1'b1, 16'hF0F0);

    // Register write with five busy cycles in between.
    step("hdr3", 1'b1, 16'hA003);
    idle("wait3", 5);
    step("data3", 1'b1, 16'h1234);
    idle("hold3", 2);

    // Timeout abandons the write; acquisition level is untouched.
    step("hdr1", 1'b1, 16'hA001);
    idle("tmo", T + 2);
    step("stop_after_tmo", 1'b1, 16'hF0F1);
    step("start_after_tmo", 1'b1, 16'hF0F0);

    // Data arriving in the last allowed cycle is still accepted.
    step("hdr5", 1'b1, 16'hA005);
    idle("edge_wait", T);
    step("edge_data", 1'b1, 16'hBEEF);
    step("hdr6", 1'b1, 16'hA006);
    idle("edge_tmo", T + 1);

    // Data words are not decoded as commands; soft reset pulse clears acquisition.
    step("swrst", 1'b1, 16'hF0FA);
    step("hdr2", 1'b1, 16'hA002);
    step("data2", 1'b1, 16'hF0F0);
    idle("after2", 1);

    // Error counting and saturation.
    async_reset("rst_err");
    step("bad_addr", 1'b1, 16'hA0FF);
    step("bad_word", 1'b1, 16'h5555);
    for (int i = 0; i < 300; i++) step("junk", 1'b1, {1'b0, 15'($urandom)});
    check("err_saturated", 32'(err_count), 32'hFF);

    // Asynchronous reset in the middle of a pending write.
    async_reset("rst_mid_pre");
    step("start_r", 1'b1, 16'hF0F0);
    step("hdr_r", 1'b1, 16'hA004);
    idle("wait_r", 3);
    async_reset("rst_mid");
    step("late_data", 1'b1, 16'h1234);
    idle("after_late", 2);

    // Random traffic, with occasional gaps straddling the timeout boundary.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 24) == 0) idle("rnd_gap", $urandom_range(T - 1, T + 2));
      else step("rnd", ($urandom_range(0, 9) < 4), rand_word());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_command_decoder.md
USB_COMMAND_DECODER -- requirements
Module: usb_command_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024: cycles allowed between a register-write header word and its data word.
REQ-002 SHALL have parameter NREG, default 8: number of addressable configuration registers; NREG <= 256.
REQ-003 SHALL have port IFCLK  input  1  clock; all logic rises on IFCLK.
REQ-004 SHALL have port nRESET  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port Ctr_rd_en  input  1  one-cycle strobe; ControlWord valid this cycle.
REQ-006 SHALL have port ControlWord  input  16  command word from the USB slave-FIFO read path.
REQ-007 SHALL have port Acq_Start_Stop  output  1  acquisition enable level; feeds the USB write path.
REQ-008 SHALL have port cfg_wr_en  output  1  one-cycle configuration write strobe.
REQ-009 SHALL have port cfg_addr  output  8  configuration register address.
REQ-010 SHALL have port cfg_data  output  16  configuration register value.
REQ-011 SHALL have port sw_reset  output  1  one-cycle soft-reset pulse to the front-end logic.
REQ-012 SHALL have port cmd_busy  output  1  high while the FSM is in WAIT_DATA.
REQ-013 SHALL have port err_count  output  8  saturating count of protocol errors.

Function
REQ-014 SHALL sample ControlWord only in cycles where Ctr_rd_en=1; all other cycles SHALL be ignored.
REQ-015 SHALL run FSM states IDLE and WAIT_DATA.
REQ-016 In IDLE, 0xF0F0 SHALL set Acq_Start_Stop=1, registered one cycle after the strobe.
REQ-017 In IDLE, 0xF0F1 SHALL clear Acq_Start_Stop to 0, one cycle after the strobe.
REQ-018 In IDLE, 0xF0FA SHALL pulse sw_reset for exactly one cycle and clear Acq_Start_Stop in the same cycle.
REQ-019 In IDLE, 0xA0nn with nn < NREG SHALL latch nn into cfg_addr, load the timeout counter with TIMEOUT and move to WAIT_DATA.
REQ-020 In WAIT_DATA, the next strobed word SHALL be placed on cfg_data with cfg_wr_en=1 for one cycle, latency 1 cycle, then the FSM SHALL return to IDLE; the word is not decoded as a command.
REQ-021 The timeout counter SHALL decrement each WAIT_DATA cycle without a strobe; on reaching 0 the FSM SHALL return to IDLE, increment err_count and issue no cfg_wr_en.
REQ-022 A strobe in the same cycle the counter reaches 0 SHALL be accepted as data; the write completes and no error is counted.
REQ-023 The following SHALL increment err_count and produce no other effect: 0xA0nn with nn >= NREG, and any unlisted word received in IDLE.
REQ-024 err_count SHALL saturate at 0xFF and never wrap.
REQ-025 Acq_Start_Stop SHALL be unaffected by register writes and by timeouts.
REQ-026 cfg_addr and cfg_data SHALL hold their last values between writes.
REQ-027 cmd_busy SHALL be 1 exactly while state = WAIT_DATA.
REQ-028 A start command while already started, or a stop while stopped, SHALL be a no-op, not an error.

Reset
REQ-029 nRESET=0 SHALL asynchronously force: state IDLE, Acq_Start_Stop=0, cfg_wr_en=0, cfg_addr=0, cfg_data=0, sw_reset=0, err_count=0, timeout counter=0.
REQ-030 Reset asserted in WAIT_DATA SHALL abandon the pending write; no cfg_wr_en SHALL be produced after release.
REQ-031 sw_reset SHALL NOT reset this block.

Verification
REQ-032 Start/stop: strobe 0xF0F0, then 0xF0F1 20 cycles later -> Acq_Start_Stop rises 1 cycle after the first strobe and falls 1 cycle after the second; err_count=0.
REQ-033 Register write: strobe 0xA003, then 0x1234 5 cycles later -> single cfg_wr_en pulse with cfg_addr=3, cfg_data=0x1234; cmd_busy high for the 5 intervening cycles.
REQ-034 Timeout: strobe 0xA001 then nothing for TIMEOUT+2 cycles -> back to IDLE, err_count=1, no cfg_wr_en; a following 0xF0F0 starts acquisition.
REQ-035 Errors: strobe 0xA0FF, then 0x5555, then 300 further invalid words -> err_count goes 1, 2, then saturates at 0xFF.
REQ-036 Data not decoded: strobe 0xA002, then 0xF0F0 -> cfg write of 0xF0F0 to address 2; Acq_Start_Stop stays 0.
REQ-037 Reset: assert nRESET mid-WAIT_DATA with Acq_Start_Stop=1 -> all outputs 0 immediately, without waiting for a clock edge; a later data word produces no write.
